// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: FSM encoding and size defaults.
package elevator_pkg;

  localparam int BUTTONS_WIDTH_DEF = 8;
  localparam int LEVEL_WIDTH_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan around one probe level: per-kind hits at the level
// and whether any request lies strictly above or below it.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEF,
  parameter int LEVEL_WIDTH   = LEVEL_WIDTH_DEF
) (
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  input  logic [LEVEL_WIDTH-1:0]   level,
  output logic [BUTTONS_WIDTH-1:0] level_onehot,
  output logic                     in_here,
  output logic                     up_here,
  output logic                     down_here,
  output logic                     any_above,
  output logic                     any_below
);

  logic [BUTTONS_WIDTH-1:0] req;
  logic [BUTTONS_WIDTH-1:0] above_mask;
  logic [BUTTONS_WIDTH-1:0] below_mask;

  assign req = active_in_levels | active_out_up_levels | active_out_down_levels;

  for (genvar gi = 0; gi < BUTTONS_WIDTH; gi++) begin : g_mask
    assign level_onehot[gi] = (level == LEVEL_WIDTH'(gi));
    assign above_mask[gi]   = (LEVEL_WIDTH'(gi) > level);
    assign below_mask[gi]   = (LEVEL_WIDTH'(gi) < level);
  end

  assign in_here   = |(active_in_levels & level_onehot);
  assign up_here   = |(active_out_up_levels & level_onehot);
  assign down_here = |(active_out_down_levels & level_onehot);
  assign any_above = |(req & above_mask);
  assign any_below = |(req & below_mask);

endmodule

// File: rtl/elevator_ctrl.sv
// Single-cabin elevator controller: direction-preference scheduling, per-level
// travel timer, door timer and one-shot clear pulses for served requests.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEF,
  parameter int LEVEL_WIDTH   = LEVEL_WIDTH_DEF,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
  output logic [LEVEL_WIDTH-1:0]   current_level,
  output logic                     motor_up,
  output logic                     motor_down,
  output logic                     door_open,
  output logic                     dir_down
);

  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCW-1:0] TRAVEL_LOAD = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LOAD   = DCW'(DOOR_CYCLES - 1);
  localparam logic [LEVEL_WIDTH-1:0] TOP_LEVEL = LEVEL_WIDTH'(BUTTONS_WIDTH - 1);

  state_t                   state_reg, state_next;
  logic [LEVEL_WIDTH-1:0]   level_reg, level_next;
  logic                     dir_down_reg, dir_down_next;
  logic [TCW-1:0]           travel_cnt_reg, travel_cnt_next;
  logic [DCW-1:0]           door_cnt_reg, door_cnt_next;
  logic                     motor_up_reg, motor_up_next;
  logic                     motor_down_reg, motor_down_next;
  logic                     door_open_reg, door_open_next;
  logic [BUTTONS_WIDTH-1:0] inact_in_reg, inact_in_next;
  logic [BUTTONS_WIDTH-1:0] inact_up_reg, inact_up_next;
  logic [BUTTONS_WIDTH-1:0] inact_down_reg, inact_down_next;

  logic [BUTTONS_WIDTH-1:0] cur_onehot, nxt_onehot, sel_onehot;
  logic cur_in, cur_up, cur_down, cur_any_above, cur_any_below;
  logic nxt_in, nxt_up, nxt_down, nxt_any_above, nxt_any_below;
  logic sel_in, sel_up, sel_down, sel_any_above, sel_any_below;
  logic [LEVEL_WIDTH-1:0]   probe_level;
  logic cur_req_here, go_up, go_down, stop_up, stop_down, enter_door;

  // Level the cabin is about to reach, clamped so it never leaves the shaft.
  always_comb begin
    probe_level = level_reg;
    if (state_reg == MOVE_DOWN) begin
      if (level_reg != '0) probe_level = level_reg - LEVEL_WIDTH'(1);
    end else if (level_reg != TOP_LEVEL) begin
      probe_level = level_reg + LEVEL_WIDTH'(1);
    end
  end

  elevator_req_scan #(
    .BUTTONS_WIDTH(BUTTONS_WIDTH),
    .LEVEL_WIDTH  (LEVEL_WIDTH)
  ) u_scan_cur (
    .active_in_levels      (active_in_levels),
    .active_out_up_levels  (active_out_up_levels),
    .active_out_down_levels(active_out_down_levels),
    .level                 (level_reg),
    .level_onehot          (cur_onehot),
    .in_here               (cur_in),
    .up_here               (cur_up),
    .down_here             (cur_down),
    .any_above             (cur_any_above),
    .any_below             (cur_any_below)
  );

  elevator_req_scan #(
    .BUTTONS_WIDTH(BUTTONS_WIDTH),
    .LEVEL_WIDTH  (LEVEL_WIDTH)
  ) u_scan_nxt (
    .active_in_levels      (active_in_levels),
    .active_out_up_levels  (active_out_up_levels),
    .active_out_down_levels(active_out_down_levels),
    .level                 (probe_level),
    .level_onehot          (nxt_onehot),
    .in_here               (nxt_in),
    .up_here               (nxt_up),
    .down_here             (nxt_down),
    .any_above             (nxt_any_above),
    .any_below             (nxt_any_below)
  );

  assign cur_req_here = cur_in | cur_up | cur_down;
  assign go_up   = dir_down_reg ? (cur_any_above & ~cur_any_below) : cur_any_above;
  assign go_down = dir_down_reg ? cur_any_below : (cur_any_below & ~cur_any_above);
  assign stop_up   = nxt_in | nxt_up | (nxt_down & ~nxt_any_above) | (probe_level == TOP_LEVEL);
  assign stop_down = nxt_in | nxt_down | (nxt_up & ~nxt_any_below) | (probe_level == '0);

  // Door opens either at the resting level (IDLE) or at the level just reached.
  assign sel_onehot    = (state_reg == IDLE) ? cur_onehot    : nxt_onehot;
  assign sel_in        = (state_reg == IDLE) ? cur_in        : nxt_in;
  assign sel_up        = (state_reg == IDLE) ? cur_up        : nxt_up;
  assign sel_down      = (state_reg == IDLE) ? cur_down      : nxt_down;
  assign sel_any_above = (state_reg == IDLE) ? cur_any_above : nxt_any_above;
  assign sel_any_below = (state_reg == IDLE) ? cur_any_below : nxt_any_below;

  always_comb begin
    state_next      = state_reg;
    level_next      = level_reg;
    dir_down_next   = dir_down_reg;
    travel_cnt_next = travel_cnt_reg;
    door_cnt_next   = door_cnt_reg;
    motor_up_next   = 1'b0;
    motor_down_next = 1'b0;
    door_open_next  = 1'b0;
    enter_door      = 1'b0;
    inact_in_next   = '0;
    inact_up_next   = '0;
    inact_down_next = '0;

    unique case (state_reg)
      IDLE: begin
        if (cur_req_here) begin
          enter_door = 1'b1;
        end else if (go_up) begin
          state_next      = MOVE_UP;
          motor_up_next   = 1'b1;
          dir_down_next   = 1'b0;
          travel_cnt_next = TRAVEL_LOAD;
        end else if (go_down) begin
          state_next      = MOVE_DOWN;
          motor_down_next = 1'b1;
          dir_down_next   = 1'b1;
          travel_cnt_next = TRAVEL_LOAD;
        end
      end
      MOVE_UP: begin
        if (travel_cnt_reg != '0) begin
          motor_up_next   = 1'b1;
          travel_cnt_next = travel_cnt_reg - TCW'(1);
        end else begin
          level_next = probe_level;
          if (stop_up) begin
            enter_door = 1'b1;
          end else begin
            motor_up_next   = 1'b1;
            travel_cnt_next = TRAVEL_LOAD;
          end
        end
      end
      MOVE_DOWN: begin
        if (travel_cnt_reg != '0) begin
          motor_down_next = 1'b1;
          travel_cnt_next = travel_cnt_reg - TCW'(1);
        end else begin
          level_next = probe_level;
          if (stop_down) begin
            enter_door = 1'b1;
          end else begin
            motor_down_next = 1'b1;
            travel_cnt_next = TRAVEL_LOAD;
          end
        end
      end
      DOOR: begin
        if (door_cnt_reg != '0) begin
          door_open_next = 1'b1;
          door_cnt_next  = door_cnt_reg - DCW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Hall calls are only cleared when the cabin will actually leave in that direction.
    if (enter_door) begin
      state_next      = DOOR;
      door_open_next  = 1'b1;
      door_cnt_next   = DOOR_LOAD;
      travel_cnt_next = '0;
      motor_up_next   = 1'b0;
      motor_down_next = 1'b0;
      inact_in_next   = sel_in ? sel_onehot : '0;
      inact_up_next   = (sel_up && (!dir_down_reg || !sel_any_below)) ? sel_onehot : '0;
      inact_down_next = (sel_down && (dir_down_reg || !sel_any_above)) ? sel_onehot : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      level_reg      <= '0;
      dir_down_reg   <= 1'b0;
      travel_cnt_reg <= '0;
      door_cnt_reg   <= '0;
      motor_up_reg   <= 1'b0;
      motor_down_reg <= 1'b0;
      door_open_reg  <= 1'b0;
      inact_in_reg   <= '0;
      inact_up_reg   <= '0;
      inact_down_reg <= '0;
    end else begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      dir_down_reg   <= dir_down_next;
      travel_cnt_reg <= travel_cnt_next;
      door_cnt_reg   <= door_cnt_next;
      motor_up_reg   <= motor_up_next;
      motor_down_reg <= motor_down_next;
      door_open_reg  <= door_open_next;
      inact_in_reg   <= inact_in_next;
      inact_up_reg   <= inact_up_next;
      inact_down_reg <= inact_down_next;
    end
  end

  assign current_level              = level_reg;
  assign dir_down                   = dir_down_reg;
  assign motor_up                   = motor_up_reg;
  assign motor_down                 = motor_down_reg;
  assign door_open                  = door_open_reg;
  assign inactivate_in_levels       = inact_in_reg;
  assign inactivate_out_up_levels   = inact_up_reg;
  assign inactivate_out_down_levels = inact_down_reg;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: vector table, directed scenarios and
// a randomized run against a behavioural model of the scheduling rules.
module tb_elevator_ctrl;

  localparam int BW = 8;
  localparam int LW = 3;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] a_in = '0, a_up = '0, a_dn = '0;
  logic [BW-1:0] i_in, i_up, i_dn;
  logic [LW-1:0] cur;
  logic          mu, md, dop, dird;

  elevator_ctrl #(
    .BUTTONS_WIDTH(BW),
    .LEVEL_WIDTH  (LW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .active_in_levels          (a_in),
    .active_out_up_levels      (a_up),
    .active_out_down_levels    (a_dn),
    .inactivate_in_levels      (i_in),
    .inactivate_out_up_levels  (i_up),
    .inactivate_out_down_levels(i_dn),
    .current_level             (cur),
    .motor_up                  (mu),
    .motor_down                (md),
    .door_open                 (dop),
    .dir_down                  (dird)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] obs();
    return {cur, mu, md, dop, dird, i_in, i_up, i_dn};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    a_in = '0; a_up = '0; a_dn = '0;
    tick();
    reset = 1'b0;
  endtask

  // Steps until door_open rises; n = cycles taken.
  task automatic wait_door(output int n);
    logic prev;
    n = 0;
    do begin
      prev = dop;
      tick();
      n++;
    end while (!(dop && !prev) && n < 100);
  endtask

  // ---------------- behavioural model ----------------
  int            m_lvl, m_move, m_tl, m_door;
  logic          m_dir;
  logic [BW-1:0] m_pin, m_pup, m_pdn;

  function automatic bit m_req(input int l);
    return a_in[l] | a_up[l] | a_dn[l];
  endfunction

  function automatic bit m_above(input int l);
    for (int k = l + 1; k < BW; k++) if (m_req(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_below(input int l);
    for (int k = 0; k < l; k++) if (m_req(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_move = 0; m_tl = 0; m_door = 0; m_dir = 1'b0;
    m_pin = '0; m_pup = '0; m_pdn = '0;
  endtask

  task automatic model_open();
    m_door = DC;
    m_move = 0;
    m_pin[m_lvl] = a_in[m_lvl];
    m_pup[m_lvl] = a_up[m_lvl] && (!m_dir || !m_below(m_lvl));
    m_pdn[m_lvl] = a_dn[m_lvl] && (m_dir || !m_above(m_lvl));
  endtask

  task automatic model_step();
    bit stop;
    m_pin = '0; m_pup = '0; m_pdn = '0;
    if (m_door > 0) begin
      m_door--;
    end else if (m_move != 0) begin
      m_tl--;
      if (m_tl == 0) begin
        m_lvl += m_move;
        if (m_move > 0)
          stop = a_in[m_lvl] || a_up[m_lvl] || (a_dn[m_lvl] && !m_above(m_lvl)) || m_lvl == BW - 1;
        else
          stop = a_in[m_lvl] || a_dn[m_lvl] || (a_up[m_lvl] && !m_below(m_lvl)) || m_lvl == 0;
        if (stop) model_open();
        else m_tl = TC;
      end
    end else if (m_req(m_lvl)) begin
      model_open();
    end else begin
      if (!m_dir) begin
        if (m_above(m_lvl)) m_move = 1;
        else if (m_below(m_lvl)) begin m_move = -1; m_dir = 1'b1; end
      end else begin
        if (m_below(m_lvl)) m_move = -1;
        else if (m_above(m_lvl)) begin m_move = 1; m_dir = 1'b0; end
      end
      if (m_move != 0) m_tl = TC;
    end
  endtask

  function automatic logic [30:0] model_out();
    return {LW'(m_lvl), m_move == 1, m_move == -1, m_door > 0, m_dir, m_pin, m_pup, m_pdn};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic [BW-1:0] in, up, dn;
    logic [LW-1:0] lvl;
    logic          mu, md, dop, dir;
    logic [BW-1:0] pin, pup, pdn;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int n;
    logic [30:0] exp;

    //              rst   in     up     dn     lvl   mu md do dir  pin    pup    pdn
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h00, 3'd0, 0, 0, 1, 0, 8'h01, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 8'h02, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 8'h02, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 8'h02, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 8'h02, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 8'h02, 8'h00, 3'd1, 0, 0, 1, 0, 8'h00, 8'h02, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 8'h00, 8'h00, 8'h01, 3'd1, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00};
    tbl[14] = '{1'b0, 8'h00, 8'h00, 8'h01, 3'd1, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00};
    tbl[15] = '{1'b0, 8'h00, 8'h00, 8'h01, 3'd1, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00};
    tbl[16] = '{1'b0, 8'h00, 8'h00, 8'h01, 3'd1, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00};
    tbl[17] = '{1'b0, 8'h00, 8'h00, 8'h01, 3'd0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h01};
    tbl[18] = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00};

    for (int r = 0; r < 19; r++) begin
      reset = tbl[r].rst;
      a_in = tbl[r].in; a_up = tbl[r].up; a_dn = tbl[r].dn;
      tick();
      exp = {tbl[r].lvl, tbl[r].mu, tbl[r].md, tbl[r].dop, tbl[r].dir,
             tbl[r].pin, tbl[r].pup, tbl[r].pdn};
      check($sformatf("table_row%0d", r), obs(), exp);
      $display("row %0d: outputs=%h expected=%h", r, obs(), exp);
    end

    // Cabin call to level 4 from rest at 0.
    do_reset();
    a_in = 8'h10;
    tick();
    check("r32_motor_up", {mu, md, dop}, 3'b100);
    wait_door(n);
    check("r32_travel_cycles", n, 16);
    check("r32_level", cur, 4);
    check("r32_clear_in", i_in, 8'h10);
    a_in = 8'h00;
    tick();
    check("r32_pulse_once", i_in, 8'h00);
    tick();
    check("r32_door_third", dop, 1'b1);
    tick();
    check("r32_door_closed", dop, 1'b0);
    $display("seq r32: arrival after %0d cycles at level %0d", n, cur);

    // Hall up at 5 and hall down at 7: stop at 5 then 7, skip 6.
    do_reset();
    a_up = 8'h20; a_dn = 8'h80;
    wait_door(n);
    check("r33_first_stop", cur, 5);
    check("r33_first_clear", {i_in, i_up, i_dn}, {8'h00, 8'h20, 8'h00});
    a_up = 8'h00;
    wait_door(n);
    check("r33_second_stop", cur, 7);
    check("r33_second_clear", {i_in, i_up, i_dn}, {8'h00, 8'h00, 8'h80});
    a_dn = 8'h00;
    $display("seq r33: second stop at level %0d", cur);

    // Preference up at 4 with calls at 6 and 1.
    do_reset();
    a_in = 8'h10;
    wait_door(n);
    a_in = 8'h42;
    wait_door(n);
    check("r34_serve_6", cur, 6);
    check("r34_dir_at_6", dird, 1'b0);
    a_in = 8'h02;
    n = 0;
    while (!md && n < 20) begin tick(); n++; end
    check("r34_dir_after_6", {md, dird}, 2'b11);
    wait_door(n);
    check("r34_serve_1", cur, 1);
    a_in = 8'h00;
    $display("seq r34: second stop at level %0d", cur);

    // Asynchronous reset while moving up at level 3.
    do_reset();
    a_in = 8'h80;
    n = 0;
    while (!(cur == 3 && mu) && n < 40) begin tick(); n++; end
    tick();
    check("r36_moving_at_3", {cur, mu}, {3'd3, 1'b1});
    #2 reset = 1'b1;
    #1;
    check("r36_async_clear", obs(), 31'd0);
    tick();
    reset = 1'b0;
    a_in = 8'h00; a_up = 8'h04;
    tick();
    check("r36_resume", {cur, mu, md, dop}, {3'd0, 3'b100});
    $display("seq r36: resumed with motor_up=%0b", mu);

    // Randomized traffic against the model; a buttons stage keeps requests pending.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int lv;
        lv = $urandom_range(0, BW - 1);
        case ($urandom_range(0, 2))
          0: a_in[lv] = 1'b1;
          1: a_up[lv] = 1'b1;
          default: a_dn[lv] = 1'b1;
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        #1;
        check("rand_async_reset", obs(), 31'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end
      model_step();
      tick();
      check($sformatf("rand_cycle%0d", c), obs(), model_out());
      check("motor_exclusive", mu & md, 1'b0);
      if (c % 100 == 0)
        $display("cycle %0d: level=%0d mu=%0b md=%0b door=%0b dir=%0b", c, cur, mu, md, dop, dird);
      a_in = a_in & ~m_pin;
      a_up = a_up & ~m_pup;
      a_dn = a_dn & ~m_pdn;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter BUTTONS_WIDTH, default 8, number of levels (one bit per level in every level vector).
REQ-002 Parameter LEVEL_WIDTH, default 3, width of current_level; SHALL satisfy 2**LEVEL_WIDTH >= BUTTONS_WIDTH.
REQ-003 Parameter TRAVEL_CYCLES, default 4, clock cycles to travel one level.
REQ-004 Parameter DOOR_CYCLES, default 3, clock cycles the door stays open.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 active_in_levels  input  BUTTONS_WIDTH  pending cabin requests from the buttons stage.
REQ-008 active_out_up_levels  input  BUTTONS_WIDTH  pending hall-up requests.
REQ-009 active_out_down_levels  input  BUTTONS_WIDTH  pending hall-down requests.
REQ-010 inactivate_in_levels  output  BUTTONS_WIDTH  one-cycle clear pulses for served cabin requests.
REQ-011 inactivate_out_up_levels  output  BUTTONS_WIDTH  one-cycle clear pulses, hall-up.
REQ-012 inactivate_out_down_levels  output  BUTTONS_WIDTH  one-cycle clear pulses, hall-down.
REQ-013 current_level  output  LEVEL_WIDTH  level the cabin is at (or last passed).
REQ-014 motor_up, motor_down  output  1 each  drive commands; never both high.
REQ-015 door_open  output  1  door command.
REQ-016 dir_down  output  1  travel preference: 0 up, 1 down.

Function
REQ-017 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR; all outputs registered.
REQ-018 req[l] = active_in|active_out_up|active_out_down at level l; any_above/any_below = OR of req strictly above/below current_level.
REQ-019 IDLE: req[current_level] -> DOOR; else continue preference (dir_down=0: any_above -> MOVE_UP, else any_below -> MOVE_DOWN and set dir_down; mirror for dir_down=1); no request -> stay IDLE.
REQ-020 Decision in IDLE takes effect next cycle: motor_* or door_open high one cycle after the request is seen.
REQ-021 MOVE_*: travel counter loads TRAVEL_CYCLES-1 on entry, decrements each cycle; at 0 current_level steps by +1/-1 and stop is evaluated on the new level.
REQ-022 Stop going up: active_in[l] | active_out_up[l] | (active_out_down[l] & no request above l) | l == BUTTONS_WIDTH-1; mirror for down with level 0.
REQ-023 No stop: counter reloads, motor stays on; stop -> DOOR, motor off same cycle door_open rises.
REQ-024 On DOOR entry, exactly one cycle of inactivate pulses: in bit always; out_up bit if dir_down=0 or no request below; out_down bit if dir_down=1 or no request above; only bits at current_level.
REQ-025 DOOR lasts DOOR_CYCLES cycles, then IDLE; requests arriving at current level during DOOR are served by IDLE re-entry (REQ-019).
REQ-026 current_level SHALL never leave 0..BUTTONS_WIDTH-1; request bits at levels >= BUTTONS_WIDTH ignored.
REQ-027 Simultaneous above and below requests: preference wins; preference flips only when no request remains in it.

Reset
REQ-028 reset high SHALL immediately force IDLE, current_level 0, dir_down 0, counters 0, motor_up/motor_down/door_open 0, all inactivate_* 0, including mid-move or mid-door.
REQ-029 First decision occurs on the first clk edge after reset deasserts.

Structure
REQ-030 Shared package elevator_pkg SHALL hold state encoding, BUTTONS_WIDTH and LEVEL_WIDTH defaults.
REQ-031 Sub-module elevator_req_scan (combinational any_above/any_below/req_here from level vectors and current_level); timers and FSM stay in elevator_ctrl.

Verification (BUTTONS_WIDTH=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-032 Idle at 0, active_in=8'h10 -> motor_up next cycle, level 4 after 16 cycles, door_open 3 cycles, inactivate_in_levels=8'h10 one cycle.
REQ-033 At 0, active_out_up=8'h20 plus active_out_down=8'h80 -> stops 5 (clears up bit 5 only), then 7 (clears down bit 7), never stops 6.
REQ-034 At 4 dir up, active_in=8'h42 -> serves 6 first, then 1; dir_down=1 after leaving 6.
REQ-035 Request at current level in IDLE -> door_open next cycle, no motor activity.
REQ-036 reset pulse mid MOVE_UP at level 3 -> all outputs 0, current_level 0 same cycle, resumes cleanly after release.
